// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, constants and address-width helper for the register file
package regfile_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREGS = 32;
  function automatic int rf_aw(int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  localparam int DEF_AW = rf_aw(DEF_NREGS);
  typedef logic [DEF_XLEN-1:0] xword_t;
  typedef logic [DEF_AW-1:0] raddr_t;
  localparam raddr_t ZERO_ADDR = '0;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback/operand-read bundle between the core and the register file
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2
);
  localparam int AW = rf_aw(NREGS);
  logic rsvEn;
  logic [AW-1:0] rsvAddr;
  logic writeEn;
  logic [AW-1:0] writeAddr;
  logic [XLEN-1:0] writeData;
  logic [NRD*AW-1:0] readAddr;
  logic [NRD*XLEN-1:0] readData;
  logic [NRD-1:0] readReady;
  logic [NREGS-1:0] busyVec;
  modport master (
    output rsvEn, rsvAddr, writeEn, writeAddr, writeData, readAddr,
    input readData, readReady, busyVec
  );
  modport slave (
    input rsvEn, rsvAddr, writeEn, writeAddr, writeData, readAddr,
    output readData, readReady, busyVec
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, set on reserve, cleared on writeback, set wins
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32
) (
  input logic clk,
  input logic arstn,
  input logic set_en_i,
  input logic [rf_aw(NREGS)-1:0] set_addr_i,
  input logic clr_en_i,
  input logic [rf_aw(NREGS)-1:0] clr_addr_i,
  output logic [NREGS-1:0] busy_o
);
  localparam int AW = rf_aw(NREGS);
  logic [NREGS-1:0] busy_q, busy_d;
  // Each bit: reserve sets, writeback clears, reserve has priority (younger producer)
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NREGS; j++)
      busy_d[j] = (set_en_i && set_addr_i == AW'(j)) || (busy_q[j] && !(clr_en_i && clr_addr_i == AW'(j)));
  end
  // Busy state register, reset drops all in-flight reservations
  always_ff @(posedge clk)
    if (!arstn) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_o = busy_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with busy scoreboard; optional write-through bypass via RF_BYPASS_EN
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic arstn,
  regfile_scoreboard_if.slave rf
);
  localparam int AW = rf_aw(NREGS);
  localparam bit ZR = ZERO_REG != 0;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy;
  logic w_ok, r_ok;
  assign w_ok = rf.writeEn && !(ZR && rf.writeAddr == AW'(ZERO_ADDR));
  assign r_ok = rf.rsvEn && !(ZR && rf.rsvAddr == AW'(ZERO_ADDR));
  rf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk(clk),
    .arstn(arstn),
    .set_en_i(r_ok),
    .set_addr_i(rf.rsvAddr),
    .clr_en_i(w_ok),
    .clr_addr_i(rf.writeAddr),
    .busy_o(busy)
  );
  // Storage: synchronous clear, single writeback port; hardwired zero is never written
  always_ff @(posedge clk)
    if (!arstn) for (int j = 0; j < NREGS; j++) regs_q[j] <= '0;
    else if (w_ok) regs_q[rf.writeAddr] <= rf.writeData;
  assign rf.busyVec = busy;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic z, hit;
    assign a = rf.readAddr[i*AW +: AW];
    assign z = ZR && a == AW'(ZERO_ADDR);
`ifdef RF_BYPASS_EN
    assign hit = w_ok && rf.writeAddr == a;
`else
    assign hit = 1'b0;
`endif
    assign rf.readData[i*XLEN +: XLEN] = z ? '0 : hit ? rf.writeData : regs_q[a];
    assign rf.readReady[i] = z || hit || !busy[a];
  end
endmodule
